// File: rtl/axis_packet_meter_pkg.sv
// Shared definitions for the AXI-Stream packet-length meter:
// keep-mask popcount, length-record layout and the default length width.
package pkt_meter_pkg;

  localparam int LW_DEFAULT = 16;   // default length field width
  localparam int KEEP_MAX   = 128;  // widest keep mask (DW = 1024)
  localparam int CNT_W      = 8;    // holds 0..KEEP_MAX bytes per beat

  // Length record as seen on the length stream: {overflow, byte length}
  typedef struct packed {
    logic                  ovf;
    logic [LW_DEFAULT-1:0] len;
  } plen_rec_t;

  // Number of set bits among the low keep_w bits of keep (holes allowed)
  function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_MAX-1:0] keep,
                                                input int                  keep_w);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      if (i < keep_w && keep[i]) n = n + CNT_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_packet_meter_if.sv
// Bundle of the three streams around the packet meter: input data stream,
// pass-through output stream and the per-packet length stream.
// slave  = the meter's view, master = the surrounding environment's view.
interface axis_packet_meter_if
  import pkt_meter_pkg::*;
#(
  parameter int DW = 128,
  parameter int LW = LW_DEFAULT
);
  logic [DW-1:0]   axis_in_tdata;
  logic [DW/8-1:0] axis_in_tkeep;
  logic            axis_in_tlast;
  logic            axis_in_tvalid;
  logic            axis_in_tready;

  logic [DW-1:0]   axis_out_tdata;
  logic [DW/8-1:0] axis_out_tkeep;
  logic            axis_out_tlast;
  logic            axis_out_tvalid;
  logic            axis_out_tready;

  logic [LW-1:0]   axis_plen_tdata;
  logic            axis_plen_tuser;
  logic            axis_plen_tvalid;
  logic            axis_plen_tready;

  modport slave (
    input  axis_in_tdata, axis_in_tkeep, axis_in_tlast, axis_in_tvalid,
    output axis_in_tready,
    output axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tvalid,
    input  axis_out_tready,
    output axis_plen_tdata, axis_plen_tuser, axis_plen_tvalid,
    input  axis_plen_tready
  );

  modport master (
    output axis_in_tdata, axis_in_tkeep, axis_in_tlast, axis_in_tvalid,
    input  axis_in_tready,
    input  axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tvalid,
    output axis_out_tready,
    input  axis_plen_tdata, axis_plen_tuser, axis_plen_tvalid,
    output axis_plen_tready
  );

endinterface

// File: rtl/axis_packet_meter_plen_fifo.sv
// First-word-fall-through FIFO for length records. Read/write pointers plus
// an occupancy count; full and empty are registered so that downstream
// gating never sees a combinational path from the pop side.
module plen_fifo
  import pkt_meter_pkg::*;
#(
  parameter int W     = LW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  // Next pointers and occupancy; push+pop together leaves the count alone
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state: pointers, count and the registered full/empty flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == (AW+1)'(DEPTH));
      empty_q  <= (cnt_d == '0);
    end
  end

  // Record storage; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/axis_packet_meter.sv
// AXI-Stream packet-length meter. Beats pass straight through; each packet's
// byte count (popcount of tkeep summed over its beats) is queued and offered
// on the length stream. A last beat stalls only while the record FIFO is full.
// Optional build macro PKT_METER_SAT_EN: saturate lengths at 2^LW-1 and flag
// the record through axis_plen_tuser; otherwise lengths wrap and tuser is 0.
module axis_packet_meter
  import pkt_meter_pkg::*;
#(
  parameter int DW         = 128,
  parameter int LW         = LW_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  axis_packet_meter_if.slave  bus,
  output logic [31:0]         pkt_count
);

  localparam int KW = DW / 8;
`ifdef PKT_METER_SAT_EN
  localparam int RW = LW + 1;
`else
  localparam int RW = LW;
`endif

  logic [CNT_W-1:0] beat_bytes;
  logic [LW-1:0]    plen;
  logic [LW-1:0]    acc_q, acc_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             fifo_full, fifo_empty;
  logic             blk, xfer, push, pop;
  logic [RW-1:0]    fifo_din, fifo_dout;

`ifdef PKT_METER_SAT_EN
  logic [LW:0]      sum;
  logic             sat_hit;
  logic             rec_ovf;
  logic             ovf_q, ovf_d;

  // Clamp an extended sum to the length field; returns {clamped, length}
  function automatic logic [LW:0] sat_len(input logic [LW:0] s);
    if (s[LW]) return {1'b1, {LW{1'b1}}};
    return {1'b0, s[LW-1:0]};
  endfunction

  assign sum              = {1'b0, acc_q} + (LW+1)'(beat_bytes);
  assign {sat_hit, plen}  = sat_len(sum);
  assign rec_ovf          = ovf_q | sat_hit;
  assign fifo_din         = {rec_ovf, plen};
  assign bus.axis_plen_tdata = fifo_dout[LW-1:0];
  assign bus.axis_plen_tuser = fifo_dout[LW];
`else
  assign plen             = acc_q + LW'(beat_bytes);
  assign fifo_din         = plen;
  assign bus.axis_plen_tdata = fifo_dout;
  assign bus.axis_plen_tuser = 1'b0;
`endif

  assign beat_bytes = popcount(KEEP_MAX'(bus.axis_in_tkeep), KW);

  // Only a last beat needs a FIFO slot, so only a last beat can be held
  assign blk                 = bus.axis_in_tlast & fifo_full;
  assign bus.axis_out_tvalid = bus.axis_in_tvalid & ~blk;
  assign bus.axis_in_tready  = bus.axis_out_tready & ~blk;
  assign bus.axis_out_tdata  = bus.axis_in_tdata;
  assign bus.axis_out_tkeep  = bus.axis_in_tkeep;
  assign bus.axis_out_tlast  = bus.axis_in_tlast;

  assign xfer = bus.axis_out_tvalid & bus.axis_out_tready;
  assign push = xfer & bus.axis_in_tlast;
  assign pop  = bus.axis_plen_tvalid & bus.axis_plen_tready;

  // Per-packet accumulation and completed-packet counting
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
`ifdef PKT_METER_SAT_EN
    ovf_d = ovf_q;
`endif
    if (xfer) begin
      if (bus.axis_in_tlast) begin
        acc_d = '0;
        cnt_d = cnt_q + 32'd1;
`ifdef PKT_METER_SAT_EN
        ovf_d = 1'b0;
`endif
      end else begin
        acc_d = plen;
`ifdef PKT_METER_SAT_EN
        ovf_d = rec_ovf;
`endif
      end
    end
  end

  // Accumulator, sticky overflow and packet counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
      cnt_q <= '0;
`ifdef PKT_METER_SAT_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
`ifdef PKT_METER_SAT_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign pkt_count = cnt_q;

  plen_fifo #(
    .W     (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_plen_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.axis_plen_tvalid = ~fifo_empty;

endmodule

// File: tb/tb_axis_packet_meter.sv
// Bench for axis_packet_meter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a record-queue model.
`timescale 1ns/1ps
module tb_axis_packet_meter;
  import pkt_meter_pkg::*;

  localparam int DW    = 128;
  localparam int LW    = 16;
  localparam int DEPTH = 4;
  localparam int NPKT  = 120;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] pkt_count, pkt_count8;
  int          total = 0;
  int          bad = 0;
  bit          rand_en = 0;

  axis_packet_meter_if #(.DW(DW), .LW(LW)) bus ();
  axis_packet_meter_if #(.DW(DW), .LW(8))  bus8 ();

  axis_packet_meter #(.DW(DW), .LW(LW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .pkt_count(pkt_count));

  axis_packet_meter #(.DW(DW), .LW(8), .FIFO_DEPTH(DEPTH)) dut8 (
    .clk(clk), .resetn(resetn), .bus(bus8), .pkt_count(pkt_count8));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected record for a packet of 'bytes' bytes, as {ovf, len}
  function automatic longint mk_rec(input longint bytes);
    longint maxv;
    maxv = (longint'(1) << LW) - 1;
`ifdef PKT_METER_SAT_EN
    if (bytes > maxv) return (longint'(1) << LW) | maxv;
    return bytes;
`else
    return bytes & maxv;
`endif
  endfunction

  // Reference model: unbounded byte total per packet, queue of records
  longint acc_m = 0;
  longint rec_q[$];
  int unsigned pcnt_m = 0;
  longint pop_log[$];
  logic   blk_m, fire_m;

  always @(negedge clk) begin
    if (!resetn) begin
      acc_m = 0;
      rec_q.delete();
      pcnt_m = 0;
      chk("rst_plen_vld", bus.axis_plen_tvalid, 1'b0);
      chk("rst_plen_data", bus.axis_plen_tdata, '0);
      chk("rst_plen_user", bus.axis_plen_tuser, 1'b0);
      chk("rst_pkt_count", pkt_count, '0);
    end else begin
      blk_m = bus.axis_in_tlast && (rec_q.size() == DEPTH);
      chk("out_tvalid", bus.axis_out_tvalid, bus.axis_in_tvalid && !blk_m);
      chk("in_tready", bus.axis_in_tready, bus.axis_out_tready && !blk_m);
      chk("out_tdata", bus.axis_out_tdata, bus.axis_in_tdata);
      chk("out_tkeep", bus.axis_out_tkeep, bus.axis_in_tkeep);
      chk("out_tlast", bus.axis_out_tlast, bus.axis_in_tlast);
      chk("pkt_count", pkt_count, pcnt_m);
      chk("plen_tvalid", bus.axis_plen_tvalid, rec_q.size() != 0);
      if (rec_q.size() != 0) begin
        chk("plen_tdata", bus.axis_plen_tdata, rec_q[0] & ((longint'(1) << LW) - 1));
        chk("plen_tuser", bus.axis_plen_tuser, rec_q[0] >> LW);
      end
      if (bus.axis_plen_tvalid && bus.axis_plen_tready) pop_log.push_back(bus.axis_plen_tdata);
      fire_m = bus.axis_in_tvalid && bus.axis_out_tready && !blk_m;
      if (bus.axis_plen_tready && rec_q.size() != 0) void'(rec_q.pop_front());
      if (fire_m) begin
        acc_m += $countones(bus.axis_in_tkeep);
        if (bus.axis_in_tlast) begin
          rec_q.push_back(mk_rec(acc_m));
          acc_m = 0;
          pcnt_m++;
        end
      end
    end
  end

  // Random backpressure on both ready inputs during the random phase
  always @(posedge clk) begin
    if (rand_en) begin
      #1;
      bus.axis_out_tready  = ($urandom_range(0, 3) != 0);
      bus.axis_plen_tready = ($urandom_range(0, 4) < 3);
    end
  end

  // Present one beat (called just after a rising edge) until it transfers
  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    bus.axis_in_tdata  = d;
    bus.axis_in_tkeep  = k;
    bus.axis_in_tlast  = l;
    bus.axis_in_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.axis_in_tready) done = 1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 500) begin
        total++;
        bad++;
        $display("FAIL beat_timeout: got no transfer expected transfer within 500 cycles");
        done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.axis_in_tvalid = 1'b0;
    bus.axis_in_tlast  = 1'b0;
    bus.axis_in_tdata  = {4{$urandom}};
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [15:0] rnd_keep();
    logic [16:0] t;
    int unsigned mode;
    mode = $urandom_range(0, 5);
    if (mode == 0) return 16'h0000;
    if (mode == 1) return 16'($urandom);
    t = (17'd1 << $urandom_range(0, 16)) - 17'd1;
    return t[15:0];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [15:0] k;
    bus.axis_in_tdata = '0;  bus.axis_in_tkeep = '0;
    bus.axis_in_tlast = 1'b0; bus.axis_in_tvalid = 1'b0;
    bus.axis_out_tready = 1'b1; bus.axis_plen_tready = 1'b1;
    bus8.axis_in_tdata = '0; bus8.axis_in_tkeep = '0;
    bus8.axis_in_tlast = 1'b0; bus8.axis_in_tvalid = 1'b0;
    bus8.axis_out_tready = 1'b1; bus8.axis_plen_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    // Single-beat packet of 8 bytes
    send_beat(rnd128(), 16'h00FF, 1'b1);
    bus.axis_in_tvalid = 1'b0;
    bus.axis_in_tlast  = 1'b0;
    @(negedge clk);
    chk("t1_vld", bus.axis_plen_tvalid, 1'b1);
    chk("t1_len", bus.axis_plen_tdata, 16'd8);
    chk("t1_cnt", pkt_count, 32'd1);
    @(posedge clk); #1;
    idle(2);

    // Three full beats plus 3 bytes: 51
    pop_log.delete();
    for (int b = 0; b < 3; b++) send_beat(rnd128(), 16'hFFFF, 1'b0);
    send_beat(rnd128(), 16'h0007, 1'b1);
    idle(4);
    chk("t2_n", pop_log.size(), 1);
    if (pop_log.size() >= 1) chk("t2_len", pop_log[0], 51);
    chk("t2_cnt", pkt_count, 32'd2);

    // Length consumer stalled: fifth last beat held until the first pop
    pop_log.delete();
    bus.axis_plen_tready = 1'b0;
    send_beat(rnd128(), 16'h0001, 1'b1);
    send_beat(rnd128(), 16'h0003, 1'b1);
    send_beat(rnd128(), 16'h0007, 1'b1);
    send_beat(rnd128(), 16'h000F, 1'b1);
    fork
      begin
        repeat (2) begin
          @(negedge clk);
          chk("t3_held_rdy", bus.axis_in_tready, 1'b0);
          chk("t3_held_vld", bus.axis_out_tvalid, 1'b0);
        end
        @(posedge clk);
        #1 bus.axis_plen_tready = 1'b1;
        @(negedge clk);
        chk("t3_still_held", bus.axis_in_tready, 1'b0);
        @(negedge clk);
        chk("t3_released", bus.axis_in_tready, 1'b1);
      end
    join_none
    send_beat(rnd128(), 16'h001F, 1'b1);
    send_beat(rnd128(), 16'h003F, 1'b1);
    idle(12);
    chk("t3_n", pop_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < pop_log.size()) chk("t3_order", pop_log[i], i + 1);
    chk("t3_cnt", pkt_count, 32'd8);

    // Randomized traffic with gaps and backpressure
    pop_log.delete();
    rand_en = 1;
    for (int p = 0; p < NPKT; p++) begin
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        k = ($urandom_range(0, 3) == 0 || b == nb - 1) ? rnd_keep() : 16'hFFFF;
        send_beat(rnd128(), k, b == nb - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    idle(1);
    rand_en = 0;
    #2;
    bus.axis_out_tready  = 1'b1;
    bus.axis_plen_tready = 1'b1;
    idle(10);
    chk("rand_cnt", pkt_count, 32'(8 + NPKT));
    chk("rand_records", pop_log.size(), NPKT);

    // Length width 8, 17 full beats = 272 bytes
    for (int b = 0; b < 17; b++) begin
      bus8.axis_in_tdata  = rnd128();
      bus8.axis_in_tkeep  = 16'hFFFF;
      bus8.axis_in_tlast  = (b == 16);
      bus8.axis_in_tvalid = 1'b1;
      @(negedge clk);
      chk("s8_rdy", bus8.axis_in_tready, 1'b1);
      @(posedge clk); #1;
    end
    bus8.axis_in_tvalid = 1'b0;
    bus8.axis_in_tlast  = 1'b0;
    @(negedge clk);
    chk("s8_vld", bus8.axis_plen_tvalid, 1'b1);
`ifdef PKT_METER_SAT_EN
    chk("s8_len", bus8.axis_plen_tdata, 8'd255);
    chk("s8_ovf", bus8.axis_plen_tuser, 1'b1);
`else
    chk("s8_len", bus8.axis_plen_tdata, 8'd16);
    chk("s8_ovf", bus8.axis_plen_tuser, 1'b0);
`endif
    chk("s8_cnt", pkt_count8, 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of a packet, then a fresh 16-byte packet
    pop_log.delete();
    send_beat(rnd128(), 16'hFFFF, 1'b0);
    send_beat(rnd128(), 16'hFFFF, 1'b0);
    bus.axis_in_tvalid = 1'b0;
    resetn = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    resetn = 1'b1;
    @(negedge clk);
    chk("t5_cnt0", pkt_count, 32'd0);
    chk("t5_vld0", bus.axis_plen_tvalid, 1'b0);
    @(posedge clk); #1;
    send_beat(rnd128(), 16'hFFFF, 1'b1);
    bus.axis_in_tvalid = 1'b0;
    bus.axis_in_tlast  = 1'b0;
    @(negedge clk);
    chk("t5_vld", bus.axis_plen_tvalid, 1'b1);
    chk("t5_len", bus.axis_plen_tdata, 16'd16);
    chk("t5_cnt", pkt_count, 32'd1);
    @(posedge clk); #1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
